// File: rtl/axi_ram_cmd_bram_mem.sv
// Byte-write, read-first synchronous single-port RAM.
// Kept as its own module so a vendor macro can replace it without touching the pipeline.
module axi_ram_cmd_bram_mem #(
    parameter int DATA_WIDTH      = 32,
    parameter int STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int WORD_ADDR_WIDTH = 14
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic                       rd_en,
    input  logic [WORD_ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic [STRB_WIDTH-1:0]      wr_strb,
    output logic [DATA_WIDTH-1:0]      rd_data
);

    localparam int DEPTH = 1 << WORD_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Registered read of the old word plus per-lane writes; both sample mem before the edge, so reads are read-first.
    // NOTE: the array has no reset on purpose -- a reset loop over every word cannot map onto block RAM, and contents must survive rst.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[addr];
        end
        for (int i = 0; i < STRB_WIDTH; i++) begin
            if (wr_en && wr_strb[i]) begin
                mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/axi_ram_cmd_bram.sv
// Block-RAM backend for the shared RAM command interface: byte-strobed writes,
// pipelined reads with valid/ready backpressure and an optional output register.
module axi_ram_cmd_bram #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 16,
    parameter int STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int ID_WIDTH        = 8,
    parameter int RUSER_WIDTH     = 1,
    parameter int PIPELINE_OUTPUT = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ID_WIDTH-1:0]    ram_cmd_id,
    input  logic [ADDR_WIDTH-1:0]  ram_cmd_addr,
    input  logic [DATA_WIDTH-1:0]  ram_cmd_wr_data,
    input  logic [STRB_WIDTH-1:0]  ram_cmd_wr_strb,
    input  logic                   ram_cmd_wr_en,
    input  logic                   ram_cmd_rd_en,
    input  logic                   ram_cmd_last,
    output logic                   ram_cmd_ready,
    output logic [ID_WIDTH-1:0]    ram_rd_resp_id,
    output logic [DATA_WIDTH-1:0]  ram_rd_resp_data,
    output logic                   ram_rd_resp_last,
    output logic [RUSER_WIDTH-1:0] ram_rd_resp_user,
    output logic                   ram_rd_resp_valid,
    input  logic                   ram_rd_resp_ready
);

    localparam int WORD_ADDR_LSB   = $clog2(STRB_WIDTH);
    localparam int WORD_ADDR_WIDTH = ADDR_WIDTH - WORD_ADDR_LSB;

    if (DATA_WIDTH != 8 * STRB_WIDTH) begin : g_width_check
        $error("axi_ram_cmd_bram: DATA_WIDTH must equal 8*STRB_WIDTH");
    end

    // Byte-offset bits inside a word do not select anything.
    if (WORD_ADDR_LSB > 0) begin : g_low_addr
        logic unused_low_addr;
        assign unused_low_addr = ^ram_cmd_addr[WORD_ADDR_LSB-1:0];
    end

    logic                  a_valid;
    logic                  a_ready;
    logic [DATA_WIDTH-1:0] a_data;
    logic [ID_WIDTH-1:0]   a_id;
    logic                  a_last;
    logic                  rd_fire;
    logic                  wr_fire;

    // Ready depends only on pipeline state and the response ready, never on the enables.
    assign ram_cmd_ready    = !a_valid || a_ready;
    assign rd_fire          = ram_cmd_rd_en && ram_cmd_ready;
    assign wr_fire          = ram_cmd_wr_en && ram_cmd_ready;
    assign ram_rd_resp_user = '0;

    axi_ram_cmd_bram_mem #(
        .DATA_WIDTH      (DATA_WIDTH),
        .STRB_WIDTH      (STRB_WIDTH),
        .WORD_ADDR_WIDTH (WORD_ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_fire),
        .rd_en   (rd_fire),
        .addr    (ram_cmd_addr[ADDR_WIDTH-1:WORD_ADDR_LSB]),
        .wr_data (ram_cmd_wr_data),
        .wr_strb (ram_cmd_wr_strb),
        .rd_data (a_data)
    );

    // Stage A valid: set on an accepted read, cleared once the beat is taken downstream.
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid <= 1'b0;
        end else if (rd_fire) begin
            a_valid <= 1'b1;
        end else if (a_ready) begin
            a_valid <= 1'b0;
        end
    end

    // Stage A sideband: captured alongside the memory read; datapath needs no reset.
    always_ff @(posedge clk) begin
        if (rd_fire) begin
            a_id   <= ram_cmd_id;
            a_last <= ram_cmd_last;
        end
    end

    if (PIPELINE_OUTPUT != 0) begin : g_stage_b
        logic                  b_valid;
        logic                  b_ready;
        logic [DATA_WIDTH-1:0] b_data;
        logic [ID_WIDTH-1:0]   b_id;
        logic                  b_last;

        assign b_ready = !b_valid || ram_rd_resp_ready;
        assign a_ready = b_ready;

        // Stage B valid: loaded from A when there is room, cleared after the response handshake.
        always_ff @(posedge clk) begin
            if (rst) begin
                b_valid <= 1'b0;
            end else if (a_valid && b_ready) begin
                b_valid <= 1'b1;
            end else if (ram_rd_resp_ready) begin
                b_valid <= 1'b0;
            end
        end

        // Stage B payload: only changes on a transfer from A, so it holds while stalled.
        always_ff @(posedge clk) begin
            if (a_valid && b_ready) begin
                b_data <= a_data;
                b_id   <= a_id;
                b_last <= a_last;
            end
        end

        assign ram_rd_resp_valid = b_valid;
        assign ram_rd_resp_data  = b_data;
        assign ram_rd_resp_id    = b_id;
        assign ram_rd_resp_last  = b_last;
    end else begin : g_stage_a_out
        assign a_ready           = ram_rd_resp_ready;
        assign ram_rd_resp_valid = a_valid;
        assign ram_rd_resp_data  = a_data;
        assign ram_rd_resp_id    = a_id;
        assign ram_rd_resp_last  = a_last;
    end

endmodule

// File: tb/tb_axi_ram_cmd_bram.sv
// Self-checking bench: drives one command stream into a PIPELINE_OUTPUT=0 and a
// PIPELINE_OUTPUT=1 instance and compares both against a transaction-level model.
module tb_axi_ram_cmd_bram;

    typedef struct {
        logic [7:0]  id;
        logic [31:0] data;
        logic        last;
        int          vis;   // first cycle the beat may appear on the response port
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cmd_id;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wr_data;
    logic [3:0]  cmd_wr_strb;
    logic        cmd_wr_en;
    logic        cmd_rd_en;
    logic        cmd_last;
    logic        resp_ready;

    logic        cready [2];
    logic [7:0]  rid    [2];
    logic [31:0] rdata  [2];
    logic        rlast  [2];
    logic [0:0]  ruser  [2];
    logic        rvalid [2];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    resp_t       q0[$];
    resp_t       q1[$];
    logic [31:0] mm [2][64];

    always #5 clk = ~clk;

    axi_ram_cmd_bram #(.PIPELINE_OUTPUT(0)) dut0 (
        .clk(clk), .rst(rst),
        .ram_cmd_id(cmd_id), .ram_cmd_addr(cmd_addr), .ram_cmd_wr_data(cmd_wr_data),
        .ram_cmd_wr_strb(cmd_wr_strb), .ram_cmd_wr_en(cmd_wr_en), .ram_cmd_rd_en(cmd_rd_en),
        .ram_cmd_last(cmd_last), .ram_cmd_ready(cready[0]),
        .ram_rd_resp_id(rid[0]), .ram_rd_resp_data(rdata[0]), .ram_rd_resp_last(rlast[0]),
        .ram_rd_resp_user(ruser[0]), .ram_rd_resp_valid(rvalid[0]), .ram_rd_resp_ready(resp_ready)
    );

    axi_ram_cmd_bram #(.PIPELINE_OUTPUT(1)) dut1 (
        .clk(clk), .rst(rst),
        .ram_cmd_id(cmd_id), .ram_cmd_addr(cmd_addr), .ram_cmd_wr_data(cmd_wr_data),
        .ram_cmd_wr_strb(cmd_wr_strb), .ram_cmd_wr_en(cmd_wr_en), .ram_cmd_rd_en(cmd_rd_en),
        .ram_cmd_last(cmd_last), .ram_cmd_ready(cready[1]),
        .ram_rd_resp_id(rid[1]), .ram_rd_resp_data(rdata[1]), .ram_rd_resp_last(rlast[1]),
        .ram_rd_resp_user(ruser[1]), .ram_rd_resp_valid(rvalid[1]), .ram_rd_resp_ready(resp_ready)
    );

    // One clock cycle: drive inputs, check both instances against the model, advance the model.
    // Model rules: instance d holds at most d+1 beats; it accepts a command when it has room or
    // the response is being taken; a beat is visible d+1 cycles after acceptance, in order.
    task automatic step(input logic wr, input logic rd, input logic [15:0] addr,
                        input logic [31:0] wd, input logic [3:0] strb, input logic [7:0] id,
                        input logic last, input logic rr, input logic r);
        logic acc [2];
        logic pop [2];
        cmd_wr_en = wr; cmd_rd_en = rd; cmd_addr = addr; cmd_wr_data = wd;
        cmd_wr_strb = strb; cmd_id = id; cmd_last = last; resp_ready = rr; rst = r;
        #1;
        for (int d = 0; d < 2; d++) begin
            resp_t h;
            int    sz;
            logic  ev;
            logic  ecr;
            if (d == 0) begin
                sz = q0.size();
                if (sz > 0) h = q0[0];
            end else begin
                sz = q1.size();
                if (sz > 0) h = q1[0];
            end
            ev  = (sz > 0) && (cyc >= h.vis);
            ecr = (sz < d + 1) || rr;
            checks++;
            if (rvalid[d] !== ev) begin
                errors++;
                $display("FAIL resp_valid dut%0d cyc %0d: got %b want %b", d, cyc, rvalid[d], ev);
            end
            checks++;
            if (cready[d] !== ecr) begin
                errors++;
                $display("FAIL cmd_ready dut%0d cyc %0d: got %b want %b", d, cyc, cready[d], ecr);
            end
            checks++;
            if (ruser[d] !== 1'b0) begin
                errors++;
                $display("FAIL resp_user dut%0d cyc %0d: got %b want 0", d, cyc, ruser[d]);
            end
            if (ev) begin
                checks++;
                if (rdata[d] !== h.data || rid[d] !== h.id || rlast[d] !== h.last) begin
                    errors++;
                    $display("FAIL resp_beat dut%0d cyc %0d: got id=%h data=%h last=%b want id=%h data=%h last=%b",
                             d, cyc, rid[d], rdata[d], rlast[d], h.id, h.data, h.last);
                end
            end
            acc[d] = ecr;
            pop[d] = ev && rr;
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (r) begin
                if (d == 0) q0.delete(); else q1.delete();
            end else begin
                resp_t n;
                if (pop[d]) begin
                    if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                end
                if (acc[d] && rd) begin
                    n.id   = id;
                    n.data = mm[d][addr[7:2]];
                    n.last = last;
                    n.vis  = cyc + d + 1;
                    if (d == 0) q0.push_back(n); else q1.push_back(n);
                end
                if (acc[d] && wr) begin
                    for (int b = 0; b < 4; b++)
                        if (strb[b]) mm[d][addr[7:2]][8*b +: 8] = wd[8*b +: 8];
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) step(0, 0, 16'h0, 32'h0, 4'h0, 8'h0, 0, rr, 0);
    endtask

    task automatic wr_word(input logic [15:0] addr, input logic [31:0] wd, input logic [3:0] strb);
        step(1, 0, addr, wd, strb, 8'h0, 0, 1, 0);
    endtask

    task automatic rd_word(input logic [15:0] addr, input logic [7:0] id, input logic last, input logic rr);
        step(0, 1, addr, 32'h0, 4'h0, id, last, rr, 0);
    endtask

    task automatic test_reset;
        step(0, 0, 16'h0, 32'h0, 4'h0, 8'h0, 0, 1, 1);
        idle(1, 1);
    endtask

    task automatic test_init_mem;
        for (int w = 0; w < 64; w++) wr_word(16'(w * 4), $urandom, 4'hF);
    endtask

    task automatic test_basic;
        wr_word(16'h0010, 32'hDEADBEEF, 4'hF);
        rd_word(16'h0010, 8'h5A, 1, 1);
        idle(3, 1);
    endtask

    task automatic test_partial_strobe;
        wr_word(16'h0020, 32'h11223344, 4'hF);
        wr_word(16'h0020, 32'hAABBCCDD, 4'h5);
        rd_word(16'h0020, 8'h21, 1, 1);
        idle(3, 1);
    endtask

    task automatic test_low_bits;
        rd_word(16'h0013, 8'h13, 0, 1);
        idle(3, 1);
    endtask

    task automatic test_backpressure;
        for (int i = 0; i < 4; i++) rd_word(16'(16'h0010 + 4 * i), 8'(8'h40 + i), i[0], 0);
        idle(3, 0);
        idle(6, 1);
    endtask

    task automatic test_back_to_back;
        wr_word(16'h0030, 32'hCAFEF00D, 4'hF);
        rd_word(16'h0030, 8'h30, 1, 1);
        wr_word(16'h0034, 32'h0BADC0DE, 4'hF);
        rd_word(16'h0034, 8'h34, 0, 1);
        idle(3, 1);
    endtask

    task automatic test_reset_mid;
        rd_word(16'h0010, 8'h01, 0, 0);
        rd_word(16'h0020, 8'h02, 1, 0);
        idle(1, 0);
        step(0, 0, 16'h0, 32'h0, 4'h0, 8'h0, 0, 0, 1);
        idle(1, 0);
        rd_word(16'h0010, 8'h03, 1, 1);
        idle(3, 1);
    endtask

    task automatic test_simultaneous;
        step(1, 1, 16'h0040, 32'h76543210, 4'hF, 8'h77, 1, 1, 0);
        rd_word(16'h0040, 8'h78, 1, 1);
        idle(3, 1);
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            int          op;
            logic [15:0] a;
            op = $urandom_range(0, 9);
            a  = 16'($urandom_range(0, 255));
            step(op >= 3 && op <= 5 || op == 9, op >= 6, a, $urandom, 4'($urandom),
                 8'($urandom), 1'($urandom), $urandom_range(0, 3) != 0, 0);
        end
        idle(6, 1);
    endtask

    initial begin
        cmd_wr_en = 0; cmd_rd_en = 0; cmd_addr = '0; cmd_wr_data = '0; cmd_wr_strb = '0;
        cmd_id = '0; cmd_last = 0; resp_ready = 1; rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        test_reset;
        test_init_mem;
        test_basic;
        test_partial_strobe;
        test_low_bits;
        test_backpressure;
        test_back_to_back;
        test_reset_mid;
        test_simultaneous;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
